// File: rtl/id_ex_stage_if.sv
// ID-to-EX stage bundle: decoded ID instruction and pipeline controls in,
// registered EX operands, stall request and stall counter out.
interface id_ex_stage_if;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic [4:0]  id_rd_i;
  logic [10:0] id_decode_i;
  logic [31:0] id_rs_data_i;
  logic [31:0] id_rt_data_i;
  logic [31:0] id_imm_i;
  logic [31:0] id_pc_i;
  logic        hold_i;
  logic        flush_i;
  logic [4:0]  ex_rs_o;
  logic [4:0]  ex_rt_o;
  logic [4:0]  ex_wr_o;
  logic [10:0] ex_decode_o;
  logic [31:0] ex_rs_data_o;
  logic [31:0] ex_rt_data_o;
  logic [31:0] ex_imm_o;
  logic [31:0] ex_pc_o;
  logic        stall_o;
  logic [15:0] stall_cnt_o;

  modport master (
    output id_rs_i, id_rt_i, id_rd_i, id_decode_i,
           id_rs_data_i, id_rt_data_i, id_imm_i, id_pc_i, hold_i, flush_i,
    input  ex_rs_o, ex_rt_o, ex_wr_o, ex_decode_o,
           ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_rd_i, id_decode_i,
           id_rs_data_i, id_rt_data_i, id_imm_i, id_pc_i, hold_i, flush_i,
    output ex_rs_o, ex_rt_o, ex_wr_o, ex_decode_o,
           ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, external hold,
// branch-flush squash and a saturating stall-cycle counter.
module id_ex_stage (
  input  logic          clk_i,
  input  logic          rst_i,
  id_ex_stage_if.slave  bus
);
  localparam int unsigned REG_W        = 5;
  localparam int unsigned DEC_W        = 11;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned MEM_READ_BIT = 9;
  localparam int unsigned REG_DST_BIT  = 4;

  logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, wr_q, wr_d;
  logic [DEC_W-1:0]  dec_q, dec_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d, pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_use_c;
  logic              stall_c;

  // Hazard detect; rt compared even when the ID instruction does not read it.
  always_comb begin
    load_use_c = dec_q[MEM_READ_BIT] && (wr_q != '0) &&
                 ((wr_q == bus.id_rs_i) || (wr_q == bus.id_rt_i));
    stall_c    = !bus.flush_i && (bus.hold_i || load_use_c);
  end

  // Next state: flush beats hold, hold beats load-use bubble.
  always_comb begin
    rs_d      = rs_q;
    rt_d      = rt_q;
    wr_d      = wr_q;
    dec_d     = dec_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;

    if (bus.flush_i || (!bus.hold_i && load_use_c)) begin
      rs_d      = '0;
      rt_d      = '0;
      wr_d      = '0;
      dec_d     = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      pc_d      = '0;
    end else if (!bus.hold_i) begin
      rs_d      = bus.id_rs_i;
      rt_d      = bus.id_rt_i;
      wr_d      = bus.id_decode_i[REG_DST_BIT] ? bus.id_rd_i : bus.id_rt_i;
      dec_d     = bus.id_decode_i;
      rs_data_d = bus.id_rs_data_i;
      rt_data_d = bus.id_rt_data_i;
      imm_d     = bus.id_imm_i;
      pc_d      = bus.id_pc_i;
    end

    if (stall_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rs_q      <= '0;
      rt_q      <= '0;
      wr_q      <= '0;
      dec_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      cnt_q     <= '0;
    end else begin
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      wr_q      <= wr_d;
      dec_q     <= dec_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.ex_rs_o      = rs_q;
  assign bus.ex_rt_o      = rt_q;
  assign bus.ex_wr_o      = wr_q;
  assign bus.ex_decode_o  = dec_q;
  assign bus.ex_rs_data_o = rs_data_q;
  assign bus.ex_rt_data_o = rt_data_q;
  assign bus.ex_imm_o     = imm_q;
  assign bus.ex_pc_o      = pc_q;
  assign bus.stall_o      = stall_c;
  assign bus.stall_cnt_o  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model.
module tb_id_ex_stage;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned rs, rt, wr, dec, rsd, rtd, imm, pc;
  } ex_t;

  ex_t m;
  int  m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hazard();
    int unsigned rs_in, rt_in;
    rs_in = int'(bus.id_rs_i);
    rt_in = int'(bus.id_rt_i);
    return ((m.dec >> 9) % 2 == 1) && m.wr != 0 && (m.wr == rs_in || m.wr == rt_in);
  endfunction

  function automatic bit model_stall();
    return !bus.flush_i && (bus.hold_i || model_hazard());
  endfunction

  // Reference model: what EX must hold after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m     = '{default: 0};
      m_cnt = 0;
    end else begin
      bit st, lu;
      st = model_stall();
      lu = model_hazard();
      if (st) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (bus.flush_i || (!bus.hold_i && lu)) begin
        m = '{default: 0};
      end else if (!bus.hold_i) begin
        m.rs  = bus.id_rs_i;
        m.rt  = bus.id_rt_i;
        m.wr  = bus.id_decode_i[4] ? bus.id_rd_i : bus.id_rt_i;
        m.dec = bus.id_decode_i;
        m.rsd = bus.id_rs_data_i;
        m.rtd = bus.id_rt_data_i;
        m.imm = bus.id_imm_i;
        m.pc  = bus.id_pc_i;
      end
    end
  end

  always @(negedge clk) begin
    chk("ex_rs",      32'(bus.ex_rs_o),     m.rs);
    chk("ex_rt",      32'(bus.ex_rt_o),     m.rt);
    chk("ex_wr",      32'(bus.ex_wr_o),     m.wr);
    chk("ex_decode",  32'(bus.ex_decode_o), m.dec);
    chk("ex_rs_data", bus.ex_rs_data_o,     m.rsd);
    chk("ex_rt_data", bus.ex_rt_data_o,     m.rtd);
    chk("ex_imm",     bus.ex_imm_o,         m.imm);
    chk("ex_pc",      bus.ex_pc_o,          m.pc);
    chk("stall",      32'(bus.stall_o),     32'(model_stall()));
    chk("stall_cnt",  32'(bus.stall_cnt_o), m_cnt);
  end

  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [10:0] dec);
    bus.id_rs_i      = rs;
    bus.id_rt_i      = rt;
    bus.id_rd_i      = rd;
    bus.id_decode_i  = dec;
    bus.id_rs_data_i = $urandom;
    bus.id_rt_data_i = $urandom;
    bus.id_imm_i     = $urandom;
    bus.id_pc_i      = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [10:0] DEC_ADD = 11'h410;
  localparam logic [10:0] DEC_LW  = 11'h6A0;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.hold_i  = 1'b0;
    bus.flush_i = 1'b0;
    drive_id(5'd0, 5'd0, 5'd0, 11'h0);
    repeat (2) step();
    rst_n = 1'b1;

    // add $3,$1,$2
    drive_id(5'd1, 5'd2, 5'd3, DEC_ADD);
    step();
    chk("add_rs",  32'(bus.ex_rs_o), 32'd1);
    chk("add_rt",  32'(bus.ex_rt_o), 32'd2);
    chk("add_wr",  32'(bus.ex_wr_o), 32'd3);
    chk("add_dec", 32'(bus.ex_decode_o), 32'h410);
    chk("add_stall", 32'(bus.stall_o), 32'd0);

    // lw $2 then add $4,$2,$5
    drive_id(5'd1, 5'd2, 5'd0, DEC_LW);
    step();
    chk("lw_wr", 32'(bus.ex_wr_o), 32'd2);
    drive_id(5'd2, 5'd5, 5'd4, DEC_ADD);
    #1;
    chk("lu_stall", 32'(bus.stall_o), 32'd1);
    step();
    chk("bubble_dec", 32'(bus.ex_decode_o), 32'd0);
    chk("bubble_cnt", 32'(bus.stall_cnt_o), 32'd1);
    chk("bubble_stall", 32'(bus.stall_o), 32'd0);
    step();
    chk("after_rs", 32'(bus.ex_rs_o), 32'd2);
    chk("after_wr", 32'(bus.ex_wr_o), 32'd4);

    // lw $0 then use of $0
    drive_id(5'd1, 5'd0, 5'd0, DEC_LW);
    step();
    drive_id(5'd0, 5'd0, 5'd6, DEC_ADD);
    #1;
    chk("zero_stall", 32'(bus.stall_o), 32'd0);
    step();
    chk("zero_dec", 32'(bus.ex_decode_o), 32'h410);

    // lw $7 then add using $1/$2
    drive_id(5'd1, 5'd7, 5'd0, DEC_LW);
    step();
    drive_id(5'd1, 5'd2, 5'd3, DEC_ADD);
    #1;
    chk("nomatch_stall", 32'(bus.stall_o), 32'd0);
    step();
    chk("nomatch_dec", 32'(bus.ex_decode_o), 32'h410);

    // 3-cycle hold with changing ID inputs
    bus.hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(5'($urandom), 5'($urandom), 5'($urandom), 11'($urandom));
      #1;
      chk("hold_stall", 32'(bus.stall_o), 32'd1);
      step();
    end
    bus.hold_i = 1'b0;
    chk("hold_cnt", 32'(bus.stall_cnt_o), 32'd4);
    chk("hold_dec", 32'(bus.ex_decode_o), 32'h410);

    // flush over hold and load-use
    drive_id(5'd1, 5'd2, 5'd0, DEC_LW);
    step();
    drive_id(5'd2, 5'd5, 5'd4, DEC_ADD);
    bus.hold_i  = 1'b1;
    bus.flush_i = 1'b1;
    #1;
    chk("flush_stall", 32'(bus.stall_o), 32'd0);
    step();
    bus.hold_i  = 1'b0;
    bus.flush_i = 1'b0;
    chk("flush_dec", 32'(bus.ex_decode_o), 32'd0);
    chk("flush_cnt", 32'(bus.stall_cnt_o), 32'd4);

    // random traffic, small register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      logic [10:0] dec;
      dec    = 11'($urandom);
      dec[9] = 1'($urandom_range(0, 1));
      drive_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), dec);
      bus.hold_i  = ($urandom_range(0, 99) < 15);
      bus.flush_i = ($urandom_range(0, 99) < 8);
      if (i == 1500) begin
        bus.hold_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_dec",  32'(bus.ex_decode_o), 32'd0);
        chk("rst_wr",   32'(bus.ex_wr_o), 32'd0);
        chk("rst_pc",   bus.ex_pc_o, 32'd0);
        chk("rst_cnt",  32'(bus.stall_cnt_o), 32'd0);
        chk("rst_stall", 32'(bus.stall_o), 32'(!bus.flush_i));
        #3;
        rst_n = 1'b1;
      end
      step();
    end

    // saturation: long hold
    bus.flush_i = 1'b0;
    bus.hold_i  = 1'b1;
    repeat (65540) step();
    bus.hold_i = 1'b0;
    chk("sat_cnt", 32'(bus.stall_cnt_o), 32'hFFFF);
    drive_id(5'd0, 5'd0, 5'd0, 11'h0);
    step();
    chk("sat_hold", 32'(bus.stall_cnt_o), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage pipelined CPU. It captures the decoded instruction from the ID stage and presents the EX-stage operands that feed the forwarding unit and ALU input muxes: rs, rt, write-back destination, the 11-bit decode bundle, and the operand data. It inserts a one-cycle bubble on a load-use dependency, holds on an external multi-cycle stall, and squashes on a branch flush. It also keeps a saturating count of stall cycles for performance debug.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register indices, 11-bit decode).
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- id_rs_i  in  5  ID source register rs
- id_rt_i  in  5  ID source register rt
- id_rd_i  in  5  ID rd field
- id_decode_i  in  11  decode bundle: [10] RegWrite, [9] MemRead, [8] MemWrite, [7] MemtoReg, [6] Branch, [5] ALUSrc, [4] RegDst, [3:0] ALUOp
- id_rs_data_i  in  32  register-file read data for rs
- id_rt_data_i  in  32  register-file read data for rt
- id_imm_i  in  32  sign-extended immediate
- id_pc_i  in  32  PC+4 of the ID instruction
- hold_i  in  1  EX/MEM multi-cycle busy; freeze this stage
- flush_i  in  1  branch taken; squash the ID instruction
- ex_rs_o  out  5  registered rs (forwarding EXRS)
- ex_rt_o  out  5  registered rt (forwarding EXRT)
- ex_wr_o  out  5  registered destination: id_rd_i if id_decode_i[4], else id_rt_i
- ex_decode_o  out  11  registered decode bundle
- ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc_o  out  32 each  registered data
- stall_o  out  1  freeze PC and IF/ID this cycle (combinational)
- stall_cnt_o  out  16  saturating count of cycles with stall_o=1

## Operation
- load_use = ex_decode_o[9] & (ex_wr_o != 0) & ((ex_wr_o == id_rs_i) | (ex_wr_o == id_rt_i)). rt is always compared, even when it is unused (conservative).
- stall_o = ~flush_i & (hold_i | load_use).
- Next-state priority at each rising edge, highest first:
  1. flush_i: load a bubble.
  2. hold_i: retain all ex_* registers.
  3. load_use: load a bubble.
  4. Otherwise: load the id_* inputs, with ex_wr_o computed from RegDst.
- Bubble: every ex_* register loads 0. Decode 0 means RegWrite=0 and MemRead=0, so the bubble triggers no forwarding and no further hazard.
- Load-use stalls exactly one cycle. After the bubble, ex_decode_o[9]=0, so the held ID instruction enters EX next cycle. The dependency is then covered by MEM→EX forwarding on the following cycle.
- stall_cnt_o increments by 1 on each edge where stall_o=1. It saturates at 16'hFFFF and does not wrap. It is cleared only by reset.
- Register $0 never causes a stall.

## Timing
- Reset (rst_i=0, asynchronous): all ex_* outputs 0 and stall_cnt_o 0, immediately and independent of clk_i. stall_o is then 0 unless hold_i=1.
- Deassertion of rst_i takes effect at the next rising edge.
- Latency: ID inputs appear on ex_* one cycle after the edge that captures them.
- stall_o is purely combinational from ex_* registers, id_rs_i, id_rt_i, hold_i and flush_i. It is valid within the same cycle and has no registered delay.
- hold_i for N cycles: ex_* registers unchanged for N edges, stall_o=1 for N cycles, stall_cnt_o advances by N.
- A load_use condition during hold_i is re-evaluated after the hold releases. No extra bubble is inserted if the dependency is gone.
- flush_i together with hold_i or load_use: the bubble loads, stall_o=0, and the counter does not increment.
- Reset asserted mid-stall clears everything. There is no residual stall after release.

## Test plan
- Reset: assert rst_i=0 mid-cycle with nonzero ex_* values -> all outputs 0 before the next edge, stall_cnt_o=0.
- Normal flow: add $3,$1,$2 (rd=3, RegDst=1, decode=11'h410) -> next cycle ex_rs_o=1, ex_rt_o=2, ex_wr_o=3, ex_decode_o=11'h410, stall_o=0.
- Load-use: lw $2 (RegWrite, MemRead, RegDst=0, rt=2) in EX with add $4,$2,$5 in ID -> stall_o=1 for one cycle, ex_decode_o=0 next cycle, then the add enters EX, stall_cnt_o=1.
- $0 and no-match: lw $0 followed by a use of $0, and lw $7 followed by add using $1/$2 -> stall_o=0, no bubble.
- Hold: hold_i=1 for 3 cycles -> ex_* frozen, stall_o=1 for 3 cycles, stall_cnt_o +3.
- Flush priority: flush_i=1 with a load-use condition and hold_i=1 -> stall_o=0, bubble loaded, counter unchanged. Separately, force 65,540 stall cycles -> stall_cnt_o holds at 16'hFFFF.
